// File: rtl/bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// bram_read_arbiter
//
// Purpose:
//   Shares one read-only BRAM port between two requesters. A winner is
//   picked while idle, its base address and burst length are captured, and
//   one address per cycle is streamed to the BRAM. Returned words are tagged
//   with the owner index. A one-cycle done pulse closes the burst.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  - when defined, simultaneous requests go to the
//                         requester that was not granted last. When it is
//                         undefined, requester 0 always wins a tie.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req[1:0]   in   level request per requester, held until its done
//   base0/1    in   first BRAM address per requester (ADDR_WIDTH)
//   len0/1     in   words to read per requester (LEN_WIDTH)
//   grant[1:0] out  one-hot current owner, zero when idle
//   rd_valid   out  a returned word is present this cycle
//   rd_data    out  returned word (W)
//   rd_id      out  owner index of the returned word
//   done[1:0]  out  one-cycle completion pulse per requester
//   busy       out  FSM is not idle
//   bram_en    out  BRAM port enable
//   bram_ren   out  BRAM read strobe, one address per cycle
//   bram_addr  out  BRAM address (ADDR_WIDTH)
//   bram_dout  in   BRAM read data (W), RD_LATENCY cycles after address
// ---------------------------------------------------------------------------
module bram_read_arbiter #(
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [ADDR_WIDTH-1:0] base0,
  input  logic [ADDR_WIDTH-1:0] base1,
  input  logic [LEN_WIDTH-1:0]  len0,
  input  logic [LEN_WIDTH-1:0]  len1,
  output logic [1:0]            grant,
  output logic                  rd_valid,
  output logic [W-1:0]          rd_data,
  output logic                  rd_id,
  output logic [1:0]            done,
  output logic                  busy,
  output logic                  bram_en,
  output logic                  bram_ren,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [W-1:0]          bram_dout
);

  localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [DW-1:0]           drain_q, drain_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d;
  logic [RD_LATENCY:0]     vld_shift;

  logic                    win;
  logic [ADDR_WIDTH-1:0]   sel_base;
  logic [LEN_WIDTH-1:0]    sel_len;

`ifdef ARB_ROUND_ROBIN_EN
  logic                    last_q;
`endif

  // Winner selection. Only consulted while idle; a single active request
  // always wins, and the configuration decides how a tie is broken. The
  // last-winner pointer resets to 1 so the first tie goes to requester 0.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    win = (req == 2'b11) ? ~last_q : req[1];
`else
    win = ~req[0];
`endif
    sel_base = win ? base1 : base0;
    sel_len  = win ? len1  : len0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero-length burst skips straight to FIN so no read
  // is ever strobed. DRAIN waits out the BRAM pipeline so the last word is
  // returned before the done pulse. FIN never arbitrates, which keeps a
  // requester that drops req on its done pulse from being granted again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = (sel_len == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (rem_q == LEN_WIDTH'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values. base/len are captured only at the grant decision,
  // so later changes on the inputs cannot disturb a running burst. The
  // address counter wraps naturally at 2^ADDR_WIDTH.
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = win;
          addr_d  = sel_base;
          rem_d   = sel_len;
        end
      end
      ISSUE: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        rem_d   = rem_q - LEN_WIDTH'(1);
        drain_d = DW'(RD_LATENCY - 1);
      end
      DRAIN: begin
        if (drain_q != '0) begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Read-valid pipeline: one bit per BRAM latency stage, fed by the read
  // strobe, so each issued address produces exactly one rd_valid.
  always_comb begin
    vld_shift = {vld_q, bram_ren};
    vld_d     = vld_shift[RD_LATENCY-1:0];
  end

  // Datapath registers. Clearing the valid pipeline on reset discards any
  // words still in flight inside the BRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      drain_q <= '0;
      vld_q   <= '0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      drain_q <= drain_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-winner pointer for tie breaking, updated on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if ((state_q == IDLE) && (|req)) begin
      last_q <= win;
    end
  end
`endif

  // Output decode. Everything is derived from registered state, so the
  // asynchronous reset forces every output to zero immediately. Returned
  // data is gated by rd_valid so nothing leaks out between words.
  always_comb begin
    busy      = (state_q != IDLE);
    grant     = 2'b00;
    done      = 2'b00;
    bram_en   = 1'b0;
    bram_ren  = 1'b0;
    bram_addr = '0;
    if (busy) begin
      grant = owner_q ? 2'b10 : 2'b01;
    end
    case (state_q)
      ISSUE: begin
        bram_en   = 1'b1;
        bram_ren  = 1'b1;
        bram_addr = addr_q;
      end
      DRAIN: begin
        bram_en = 1'b1;
      end
      FIN: begin
        done = owner_q ? 2'b10 : 2'b01;
      end
      default: begin
      end
    endcase
    rd_valid = vld_q[RD_LATENCY-1];
    rd_data  = rd_valid ? bram_dout : '0;
    rd_id    = rd_valid & owner_q;
  end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_read_arbiter
//
// Self-checking bench for bram_read_arbiter with default parameters. A
// small BRAM model returns addr[7:0] RD_LATENCY cycles after each address.
// Expected addresses and returned words are queued when a request is
// driven and popped as the DUT strobes reads or returns data.
// ---------------------------------------------------------------------------
module tb_bram_read_arbiter;

  localparam int W  = 8;
  localparam int AW = 11;
  localparam int LW = 12;
  localparam int RL = 2;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req;
  logic [AW-1:0] base0, base1;
  logic [LW-1:0] len0, len1;
  logic [1:0]    grant;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_id;
  logic [1:0]    done;
  logic          busy;
  logic          bram_en;
  logic          bram_ren;
  logic [AW-1:0] bram_addr;
  logic [W-1:0]  bram_dout;

  logic [AW-1:0] bram_pipe [RL];

  int total;
  int bad;
  int ren_cnt;
  int rv_cnt;
  int done_cnt [2];

  logic [AW-1:0] q_addr [$];
  logic [8:0]    q_rd   [$];

  bram_read_arbiter #(
    .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .base0(base0), .base1(base1), .len0(len0), .len1(len1),
    .grant(grant), .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id),
    .done(done), .busy(busy),
    .bram_en(bram_en), .bram_ren(bram_ren), .bram_addr(bram_addr),
    .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: read data is the low byte of the address presented
  // RL cycles earlier.
  always @(posedge clk) begin
    bram_pipe[0] <= bram_addr;
    for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign bram_dout = bram_pipe[RL-1][7:0];

  // Advance to the next falling edge and run the scoreboard on that cycle.
  task automatic tick();
    logic [AW-1:0] ea;
    logic [8:0]    er;
    @(negedge clk);
    if (bram_ren === 1'b1) begin
      ren_cnt++;
      total++;
      if (q_addr.size() == 0) begin
        bad++;
        $display("[TB] FAIL addr_unexpected got=%0d need=none", bram_addr);
      end else begin
        ea = q_addr.pop_front();
        if ({bram_en, bram_addr} !== {1'b1, ea}) begin
          bad++;
          $display("[TB] FAIL addr got=en%0b/%0d need=en1/%0d", bram_en, bram_addr, ea);
        end
      end
    end
    if (rd_valid === 1'b1) begin
      rv_cnt++;
      total++;
      if (q_rd.size() == 0) begin
        bad++;
        $display("[TB] FAIL rd_unexpected got=id%0b/%0h need=none", rd_id, rd_data);
      end else begin
        er = q_rd.pop_front();
        if ({rd_id, rd_data} !== er) begin
          bad++;
          $display("[TB] FAIL rd_data got=id%0b/%0h need=id%0b/%0h", rd_id, rd_data, er[8], er[7:0]);
        end
      end
    end
    if (done[0] === 1'b1) done_cnt[0]++;
    if (done[1] === 1'b1) done_cnt[1]++;
  endtask

  task automatic push_exp(input logic [AW-1:0] b, input logic [LW-1:0] n, input logic id);
    logic [AW-1:0] a;
    for (int k = 0; k < int'(n); k++) begin
      a = b + AW'(k);
      q_addr.push_back(a);
      q_rd.push_back({id, a[7:0]});
    end
  endtask

  task automatic wait_done(input int id, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done[id] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    base0 = '0; base1 = '0; len0 = '0; len1 = '0;
    #1;
    total++;
    if (grant !== 2'b00) begin bad++; $display("[TB] FAIL reset_grant got=%0b need=00", grant); end
    total++;
    if ({done, busy} !== 3'b000) begin bad++; $display("[TB] FAIL reset_done_busy got=%0b need=000", {done, busy}); end
    total++;
    if ({rd_valid, rd_id, rd_data} !== 10'd0) begin bad++; $display("[TB] FAIL reset_rd got=%0h need=0", {rd_valid, rd_id, rd_data}); end
    total++;
    if ({bram_en, bram_ren, bram_addr} !== 13'd0) begin bad++; $display("[TB] FAIL reset_bram got=%0h need=0", {bram_en, bram_ren, bram_addr}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit seen;
    int v0, d0;
    base0 = AW'(512); len0 = LW'(4);
    push_exp(AW'(512), LW'(4), 1'b0);
    v0 = rv_cnt; d0 = done_cnt[0];
    req = 2'b01;
    tick();
    total++;
    if ({grant, busy} !== 3'b011) begin bad++; $display("[TB] FAIL single_grant got=%0b need=011", {grant, busy}); end
    wait_done(0, 50, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL single_done_timeout got=0 need=1"); end
    req = 2'b00;
    tick();
    total++;
    if ({grant, done, busy} !== 5'b00000) begin bad++; $display("[TB] FAIL single_release got=%0b need=00000", {grant, done, busy}); end
    total++;
    if (rv_cnt - v0 !== 4) begin bad++; $display("[TB] FAIL single_rd_count got=%0d need=4", rv_cnt - v0); end
    tick(); tick(); tick();
    total++;
    if (done_cnt[0] - d0 !== 1) begin bad++; $display("[TB] FAIL single_done_count got=%0d need=1", done_cnt[0] - d0); end
    total++;
    if (q_addr.size() + q_rd.size() !== 0) begin bad++; $display("[TB] FAIL single_leftover got=%0d need=0", q_addr.size() + q_rd.size()); end
  endtask

  task automatic test_wrap();
    bit seen;
    int v0;
    base1 = AW'(2046); len1 = LW'(4);
    push_exp(AW'(2046), LW'(4), 1'b1);
    v0 = rv_cnt;
    req = 2'b10;
    tick();
    total++;
    if (grant !== 2'b10) begin bad++; $display("[TB] FAIL wrap_grant got=%0b need=10", grant); end
    wait_done(1, 50, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL wrap_done_timeout got=0 need=1"); end
    req = 2'b00;
    tick();
    total++;
    if (rv_cnt - v0 !== 4) begin bad++; $display("[TB] FAIL wrap_rd_count got=%0d need=4", rv_cnt - v0); end
    total++;
    if (q_addr.size() + q_rd.size() !== 0) begin bad++; $display("[TB] FAIL wrap_leftover got=%0d need=0", q_addr.size() + q_rd.size()); end
  endtask

  task automatic test_len_zero();
    int r0, v0;
    base0 = AW'(50); len0 = LW'(0);
    r0 = ren_cnt; v0 = rv_cnt;
    req = 2'b01;
    tick();
    total++;
    if ({grant, done, bram_ren} !== 5'b01010) begin bad++; $display("[TB] FAIL len0_fin got=%0b need=01010", {grant, done, bram_ren}); end
    req = 2'b00;
    repeat (5) tick();
    total++;
    if ((ren_cnt - r0) + (rv_cnt - v0) !== 0) begin bad++; $display("[TB] FAIL len0_reads got=%0d need=0", (ren_cnt - r0) + (rv_cnt - v0)); end
    total++;
    if ({grant, busy} !== 3'b000) begin bad++; $display("[TB] FAIL len0_idle got=%0b need=000", {grant, busy}); end
  endtask

  task automatic serve_one();
    bit seen;
    base0 = AW'(10); len0 = LW'(2);
    push_exp(AW'(10), LW'(2), 1'b0);
    req = 2'b01;
    wait_done(0, 50, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL one_done_timeout got=0 need=1"); end
    req = 2'b00;
    tick();
  endtask

  task automatic serve_pair(input logic first);
    bit   seen;
    logic other;
    other = ~first;
    base0 = AW'(10); len0 = LW'(2);
    base1 = AW'(20); len1 = LW'(3);
    if (first) push_exp(AW'(20), LW'(3), 1'b1);
    else       push_exp(AW'(10), LW'(2), 1'b0);
    req = 2'b11;
    tick();
    total++;
    if (grant !== (first ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL pair_first got=%0b need=%0b", grant, first ? 2'b10 : 2'b01); end
    wait_done(int'(first), 50, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL pair_first_timeout got=0 need=1"); end
    req[first] = 1'b0;
    if (other) push_exp(AW'(20), LW'(3), 1'b1);
    else       push_exp(AW'(10), LW'(2), 1'b0);
    tick(); tick();
    total++;
    if (grant !== (other ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL pair_second got=%0b need=%0b", grant, other ? 2'b10 : 2'b01); end
    wait_done(int'(other), 50, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL pair_second_timeout got=0 need=1"); end
    req = 2'b00;
    tick();
    total++;
    if (q_addr.size() + q_rd.size() !== 0) begin bad++; $display("[TB] FAIL pair_leftover got=%0d need=0", q_addr.size() + q_rd.size()); end
  endtask

  task automatic test_arbitration();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    tick();
    serve_pair(1'b0);
    serve_pair(1'b0);
    serve_one();
`ifdef ARB_ROUND_ROBIN_EN
    serve_pair(1'b1);
`else
    serve_pair(1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    int v0, d0;
    base0 = AW'(300); len0 = LW'(8);
    push_exp(AW'(300), LW'(8), 1'b0);
    req = 2'b01;
    tick(); tick(); tick();
    v0 = rv_cnt; d0 = done_cnt[0] + done_cnt[1];
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    total++;
    if ({grant, busy, done} !== 5'b00000) begin bad++; $display("[TB] FAIL rstmid_ctrl got=%0b need=00000", {grant, busy, done}); end
    total++;
    if ({rd_valid, rd_id, rd_data} !== 10'd0) begin bad++; $display("[TB] FAIL rstmid_rd got=%0h need=0", {rd_valid, rd_id, rd_data}); end
    total++;
    if ({bram_en, bram_ren, bram_addr} !== 13'd0) begin bad++; $display("[TB] FAIL rstmid_bram got=%0h need=0", {bram_en, bram_ren, bram_addr}); end
    q_addr.delete();
    q_rd.delete();
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    total++;
    if (rv_cnt - v0 !== 0) begin bad++; $display("[TB] FAIL rstmid_rd_after got=%0d need=0", rv_cnt - v0); end
    total++;
    if (done_cnt[0] + done_cnt[1] - d0 !== 0) begin bad++; $display("[TB] FAIL rstmid_done_after got=%0d need=0", done_cnt[0] + done_cnt[1] - d0); end
  endtask

  task automatic test_hold_change();
    bit seen;
    int v0;
    base0 = AW'(600); len0 = LW'(5);
    push_exp(AW'(600), LW'(5), 1'b0);
    v0 = rv_cnt;
    req = 2'b01;
    tick();
    total++;
    if (grant !== 2'b01) begin bad++; $display("[TB] FAIL hold_grant got=%0b need=01", grant); end
    req   = 2'b00;
    base0 = AW'(100);
    len0  = LW'(1);
    wait_done(0, 50, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL hold_done_timeout got=0 need=1"); end
    tick();
    total++;
    if (rv_cnt - v0 !== 5) begin bad++; $display("[TB] FAIL hold_rd_count got=%0d need=5", rv_cnt - v0); end
    total++;
    if (q_addr.size() + q_rd.size() !== 0) begin bad++; $display("[TB] FAIL hold_leftover got=%0d need=0", q_addr.size() + q_rd.size()); end
  endtask

  initial begin
    total = 0; bad = 0; ren_cnt = 0; rv_cnt = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    test_reset();
    test_single();
    test_wrap();
    test_len_zero();
    test_arbitration();
    test_reset_mid();
    test_hold_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_read_arbiter.md
BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning BRAM data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 11, meaning BRAM address width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 12, meaning burst-length counter width.
REQ-004 The block SHALL have parameter RD_LATENCY, default 2, meaning BRAM cycles from address to dout.
REQ-005 The block SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-007 The block SHALL have port req, input, 2, meaning per-requester level request, held until matching done.
REQ-008 The block SHALL have ports base0 and base1, input, ADDR_WIDTH each, meaning first BRAM address per requester.
REQ-009 The block SHALL have ports len0 and len1, input, LEN_WIDTH each, meaning words to read per requester.
REQ-010 The block SHALL have port grant, output, 2, meaning one-hot current owner, all-zero when idle.
REQ-011 The block SHALL have ports rd_valid (output, 1), rd_data (output, W) and rd_id (output, 1), meaning a returned word and its owner index.
REQ-012 The block SHALL have port done, output, 2, meaning one-cycle completion pulse per requester.
REQ-013 The block SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-014 The block SHALL have ports bram_en, bram_ren (output, 1 each), bram_addr (output, ADDR_WIDTH) and bram_dout (input, W), meaning the read-only BRAM port; the BRAM write enable is tied low outside this block.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, DRAIN and FIN.
REQ-016 In IDLE with any req bit high, the block SHALL select a winner, latch its base/len, assert grant next cycle and enter ISSUE; with len 0 it SHALL enter FIN directly and issue no reads.
REQ-017 In ISSUE, per cycle, the block SHALL drive bram_en=bram_ren=1 and bram_addr=base+k, k=0..len-1, one address per cycle with no gaps.
REQ-018 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; base=2047 with len=3 reads 2047, 0, 1.
REQ-019 After issuing address len-1, the block SHALL enter DRAIN, drop bram_ren and keep bram_en high for RD_LATENCY cycles.
REQ-020 rd_valid SHALL assert exactly RD_LATENCY cycles after each issued address, carrying bram_dout and rd_id=owner, for exactly len cycles total.
REQ-021 In FIN, the block SHALL pulse done[owner] for one cycle, clear grant, bram_en and busy, and return to IDLE; no new grant SHALL occur in the FIN cycle.
REQ-022 Deassertion of req during a transfer SHALL be ignored; transfers SHALL never be aborted.
REQ-023 base and len SHALL be sampled only at grant; later changes SHALL not affect the active transfer.

Reset
REQ-024 rst_n low SHALL immediately force IDLE with grant, rd_valid, rd_data, rd_id, done, busy, bram_en, bram_ren and bram_addr all zero; the last-winner pointer SHALL reset to 1.
REQ-025 Reset mid-transfer SHALL discard in-flight data; no rd_valid or done SHALL follow release.

Configuration
REQ-026 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last; without it, requester 0 SHALL always win simultaneous requests.

Verification
REQ-027 req=01, base0=512, len0=4, bram_dout=addr[7:0] -> addresses 512..515 on consecutive cycles; rd_data 0,1,2,3 with rd_id=0; done[0] pulses once.
REQ-028 req=11 after reset with ARB_ROUND_ROBIN_EN -> requester 0 served, then requester 1; a repeat pair then alternates 0,1; without the macro requester 0 is served each time both are high.
REQ-029 base1=2046, len1=4 -> addresses 2046, 2047, 0, 1; four rd_valid with rd_id=1.
REQ-030 len0=0 -> no bram_ren, no rd_valid, done[0] one cycle after grant.
REQ-031 rst_n low at third read of len0=8 -> all outputs zero asynchronously; after release no rd_valid or done until a new req.
REQ-032 req0 dropped after grant of len0=5, with base0 changed to 100 -> original five addresses complete and done[0] pulses.
